estagio_decodificacao: RTL

- Decode/operand-fetch stage directly upstream of the 16-bit execute ALU.
- Accepts 16-bit instruction words from fetch and holds the 16x16 register file.
- Resolves read-after-write and write-after-write hazards with a per-register pending scoreboard.
- Delivers a registered {codop, operando1, operando2, dest} bundle to execute over a valid/ready handshake; receives ALU results back on a writeback port.

---
 rtl/estagio_decodificacao_pkg.sv | 56 +++++
 rtl/estagio_decodificacao_banco_registradores.sv | 51 +++++
 rtl/estagio_decodificacao.sv | 137 +++++++++++++
 3 files changed

// File: rtl/estagio_decodificacao_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_isa
// Purpose  : ISA constants for the decode stage. This file defines the opcode
//            values, the instruction field positions and the opcode classes.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_isa;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  // Opcodes understood by the execute ALU
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SLLI = 4'd7;
  localparam logic [3:0] OP_SRLI = 4'd8;
  localparam logic [3:0] OP_ADIS = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MOV  = 4'd11;
  localparam logic [3:0] OP_BEQZ = 4'd12;

  // Opcode classes, one bit per opcode value
  localparam logic [15:0] OPS_IMEDIATO = 16'b0000_0011_1100_0000; // 6,7,8,9
  localparam logic [15:0] OPS_SINAL    = 16'b0000_0010_0000_0000; // 9
  localparam logic [3:0]  OP_ILEGAL_MIN = 4'd13;                  // 13..15

  // The rs2 field carries an immediate rather than a register index
  function automatic logic eh_imediato(input logic [3:0] op);
    return OPS_IMEDIATO[op];
  endfunction

  // The immediate is sign-extended rather than zero-extended
  function automatic logic eh_sinal(input logic [3:0] op);
    return OPS_SINAL[op];
  endfunction

  // The opcode is outside the defined ALU range
  function automatic logic eh_ilegal(input logic [3:0] op);
    return op >= OP_ILEGAL_MIN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/estagio_decodificacao_banco_registradores.sv
`default_nettype none
// ============================================================================
// Module   : banco_registradores
// Purpose  : Register file with two combinational read ports and one write
//            port. Register r0 always reads as zero, and a write made in the
//            same cycle as a read is forwarded to that read.
// Revision : 1.0 - initial release
// ============================================================================
module banco_registradores #(
  parameter int NREG    = 16,
  parameter int LARGURA = 16,
  parameter int AW      = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [LARGURA-1:0] wdata_i,
  input  logic [AW-1:0]      raddr1_i,
  input  logic [AW-1:0]      raddr2_i,
  output logic [LARGURA-1:0] rdata1_o,
  output logic [LARGURA-1:0] rdata2_o
);

  logic [LARGURA-1:0] regs_q [NREG];

  // Storage update: r0 is never written, so it keeps its reset value of zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: a same-cycle write is forwarded, and index 0 is forced to zero
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (raddr1_i == '0)                rdata1_o = '0;
  end

  // Read port 2: same forwarding rule as port 1
  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr2_i == '0)                rdata2_o = '0;
  end

endmodule
`default_nettype wire

// File: rtl/estagio_decodificacao.sv
`default_nettype none
// ============================================================================
// Module   : estagio_decodificacao
// Purpose  : Decode and operand-fetch stage. It reads operands from the
//            register file, stalls on pending registers, and delivers a
//            registered bundle to execute over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module estagio_decodificacao
  import pkg_isa::*;
#(
  parameter int NREG    = 16,
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         codop,
  output logic [LARGURA-1:0] operando1,
  output logic [LARGURA-1:0] operando2,
  output logic [3:0]         dest,
  output logic               illegal,
  input  logic               wb_en,
  input  logic [3:0]         wb_dest,
  input  logic [LARGURA-1:0] wb_data
);

  logic [3:0] w_op, w_rd, w_rs1, w_rs2;
  logic       w_ilegal, w_usa_rs2, w_ocup1, w_ocup2, w_ocup_rd, w_hazard;
  logic       w_aceita, w_emite;
  logic [LARGURA-1:0] w_rdata1, w_rdata2, w_op2;

  logic               out_valid_q, out_valid_d;
  logic               illegal_q, illegal_d;
  logic [3:0]         codop_q, codop_d, dest_q, dest_d;
  logic [LARGURA-1:0] operando1_q, operando1_d, operando2_q, operando2_d;
  logic [NREG-1:0]    pending_q, pending_d;

  assign w_op  = instr[OP_MSB:OP_LSB];
  assign w_rd  = instr[RD_MSB:RD_LSB];
  assign w_rs1 = instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = instr[RS2_MSB:RS2_LSB];

  // The writeback port doubles as the register file write port, so its
  // forwarding also provides the operand bypass
  banco_registradores #(
    .NREG    (NREG),
    .LARGURA (LARGURA)
  ) u_banco (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wb_en),
    .waddr_i  (wb_dest),
    .wdata_i  (wb_data),
    .raddr1_i (w_rs1),
    .raddr2_i (w_rs2),
    .rdata1_o (w_rdata1),
    .rdata2_o (w_rdata2)
  );

  // Hazard detection: a pending source that is written back in this cycle is
  // already resolved by the bypass; a pending destination always stalls
  always_comb begin
    w_ilegal  = eh_ilegal(w_op);
    w_usa_rs2 = ~eh_imediato(w_op) & (w_op != OP_MOV);
    w_ocup1   = pending_q[w_rs1] & ~(wb_en & (wb_dest == w_rs1));
    w_ocup2   = pending_q[w_rs2] & ~(wb_en & (wb_dest == w_rs2)) & w_usa_rs2;
    w_ocup_rd = pending_q[w_rd] & (w_rd != 4'd0);
    w_hazard  = ~w_ilegal & (w_ocup1 | w_ocup2 | w_ocup_rd);
  end

  assign instr_ready = (~out_valid_q | out_ready) & ~w_hazard;
  assign w_aceita    = instr_valid & instr_ready;
  assign w_emite     = w_aceita & ~w_ilegal;

  // Second operand selection: immediate, sign-extended immediate, zero, or rs2
  always_comb begin
    w_op2 = w_rdata2;
    if (eh_sinal(w_op))          w_op2 = {{(LARGURA-4){w_rs2[3]}}, w_rs2};
    else if (eh_imediato(w_op))  w_op2 = {{(LARGURA-4){1'b0}}, w_rs2};
    else if (w_op == OP_MOV)     w_op2 = '0;
  end

  // Next-state: load the bundle on a legal accept, hold it otherwise, and
  // update the scoreboard so that a set wins over a same-index clear
  always_comb begin
    out_valid_d = w_emite | (out_valid_q & ~out_ready);
    illegal_d   = illegal_q | (w_aceita & w_ilegal);
    codop_d     = codop_q;
    dest_d      = dest_q;
    operando1_d = operando1_q;
    operando2_d = operando2_q;
    if (w_emite) begin
      codop_d     = w_op;
      dest_d      = w_rd;
      operando1_d = w_rdata1;
      operando2_d = w_op2;
    end
    pending_d = pending_q;
    if (wb_en) pending_d[wb_dest] = 1'b0;
    if (w_emite && (w_rd != 4'd0)) pending_d[w_rd] = 1'b1;
  end

  // State registers: reset overrides any concurrent accept or writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      codop_q     <= '0;
      dest_q      <= '0;
      operando1_q <= '0;
      operando2_q <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      codop_q     <= codop_d;
      dest_q      <= dest_d;
      operando1_q <= operando1_d;
      operando2_q <= operando2_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign codop     = codop_q;
  assign dest      = dest_q;
  assign operando1 = operando1_q;
  assign operando2 = operando2_q;

endmodule
`default_nettype wire
